// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt scheduler
package irq_pkg;

    localparam int NVEC  = 8;
    localparam int VEC_W = 3;

    localparam logic [VEC_W-1:0] VEC_TIMER = 3'd1;
    localparam logic [VEC_W-1:0] VEC_KEYB  = 3'd2;
    localparam logic [VEC_W-1:0] VEC_SPI   = 3'd3;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_EOI = 1'b1
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-set-bit priority encoder with valid flag
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NVEC-1:0]  i_req,
    output logic [VEC_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan downward so the lowest-numbered request overwrites any higher one.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        for (int i = NVEC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritised, EOI-gated interrupt dispatcher for the AVR core
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int EOI_TIMEOUT = 0,
    parameter int TMR_W       = 16
)
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NVEC-1:0]  irq_src,
    input  logic             mask_we,
    input  logic [NVEC-1:0]  mask_d,
    input  logic             eoi,
    input  logic [NVEC-1:0]  sw_set,
    output logic             intr,
    output logic [VEC_W-1:0] vect,
    output logic [NVEC-1:0]  pending,
    output logic [NVEC-1:0]  mask,
    output logic             in_service,
    output logic             eoi_lost
);

    localparam bit               WDOG_EN  = (EOI_TIMEOUT != 0);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(EOI_TIMEOUT - 1);

    irq_state_t        r_state;
    logic [NVEC-1:0]   r_src;
    logic [NVEC-1:0]   r_pending;
    logic [NVEC-1:0]   r_mask;
    logic [TMR_W-1:0]  r_cnt;
    logic              r_intr;
    logic [VEC_W-1:0]  r_vect;
    logic              r_in_service;
    logic              r_eoi_lost;

    logic [NVEC-1:0]   w_raw;
    logic [NVEC-1:0]   w_live;
    logic [NVEC-1:0]   w_new_mask;
    logic [NVEC-1:0]   w_clr;
    logic [NVEC-1:0]   w_pending_nxt;
    logic [VEC_W-1:0]  w_win;
    logic              w_win_valid;
    logic              w_dispatch;
    logic              w_tmo;

    // Vector 0 is the reset vector and can never be requested.
    assign w_raw      = ((irq_src & ~r_src) | sw_set) & ~NVEC'(1);
    assign w_live     = r_pending & r_mask;
    assign w_new_mask = mask_we ? mask_d : r_mask;

    irq_prio_enc u_prio_enc (
        .i_req   (w_live),
        .o_idx   (w_win),
        .o_valid (w_win_valid)
    );

    assign w_dispatch = (r_state == IDLE) && w_win_valid;
    assign w_clr      = w_dispatch ? (NVEC'(1) << w_win) : '0;
    assign w_tmo      = WDOG_EN && (r_cnt == TMO_LAST);

    // New edges are OR-ed in last so a fresh request survives its own dispatch.
    always_comb begin
        w_pending_nxt = r_pending & ~w_clr;
        if (mask_we) begin
            w_pending_nxt = w_pending_nxt & mask_d;
        end
        w_pending_nxt = w_pending_nxt | (w_raw & w_new_mask);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_src        <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_intr       <= 1'b0;
            r_vect       <= '0;
            r_in_service <= 1'b0;
            r_eoi_lost   <= 1'b0;
        end else begin
            r_src      <= irq_src;
            r_pending  <= w_pending_nxt;
            r_eoi_lost <= 1'b0;
            if (mask_we) begin
                r_mask <= mask_d;
            end
            case (r_state)
                IDLE: begin
                    if (w_dispatch) begin
                        r_state      <= WAIT_EOI;
                        r_vect       <= w_win;
                        r_intr       <= ~r_intr;
                        r_cnt        <= '0;
                        r_in_service <= 1'b1;
                    end
                end
                WAIT_EOI: begin
                    if (eoi) begin
                        r_state      <= IDLE;
                        r_in_service <= 1'b0;
                    end else if (w_tmo) begin
                        r_state      <= IDLE;
                        r_in_service <= 1'b0;
                        r_eoi_lost   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + TMR_W'(1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign intr       = r_intr;
    assign vect       = r_vect;
    assign pending    = r_pending;
    assign mask       = r_mask;
    assign in_service = r_in_service;
    assign eoi_lost   = r_eoi_lost;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl with a behavioural model
module tb_irq_ctrl;
    import irq_pkg::*;

    localparam int TMO = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] irq_src = '0;
    logic       mask_we = 1'b0;
    logic [7:0] mask_d = '0;
    logic       eoi = 1'b0;
    logic [7:0] sw_set = '0;
    logic       intr;
    logic [2:0] vect;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       in_service;
    logic       eoi_lost;

    int errors = 0;
    int checks = 0;

    // Behavioural model: set of waiting requests, busy flag and service age.
    logic [7:0] m_prev_src, m_pending, m_mask;
    logic       m_intr, m_busy, m_lost;
    logic [2:0] m_vect;
    int         m_age;

    irq_ctrl #(.EOI_TIMEOUT(TMO), .TMR_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .irq_src(irq_src), .mask_we(mask_we),
        .mask_d(mask_d), .eoi(eoi), .sw_set(sw_set), .intr(intr), .vect(vect),
        .pending(pending), .mask(mask), .in_service(in_service), .eoi_lost(eoi_lost)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_prev_src = '0; m_pending = '0; m_mask = '0;
        m_intr = 1'b0; m_busy = 1'b0; m_lost = 1'b0; m_vect = '0; m_age = 0;
    endtask

    task automatic model_step();
        logic [7:0] events;
        logic [7:0] eff_mask;
        logic [7:0] waiting;
        int winner;
        events   = ((irq_src & ~m_prev_src) | sw_set) & 8'hFE;
        eff_mask = mask_we ? mask_d : m_mask;
        waiting  = m_pending & m_mask;
        m_lost   = 1'b0;
        if (mask_we) m_pending = m_pending & mask_d;
        if (!m_busy) begin
            winner = -1;
            for (int i = 7; i >= 1; i--) if (waiting[i]) winner = i;
            if (winner > 0) begin
                m_pending[winner] = 1'b0;
                m_vect = 3'(winner);
                m_intr = ~m_intr;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else if (eoi) begin
            m_busy = 1'b0;
        end else if (m_age + 1 == TMO) begin
            m_busy = 1'b0;
            m_lost = 1'b1;
        end else begin
            m_age++;
        end
        m_pending  = m_pending | (events & eff_mask);
        m_mask     = eff_mask;
        m_prev_src = irq_src;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        irq_src = '0; sw_set = '0; mask_we = 1'b0; mask_d = '0; eoi = 1'b0;
        reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we = 1'b1; mask_d = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse_src(input logic [7:0] s);
        irq_src = s;
        tick();
        irq_src = '0;
    endtask

    task automatic send_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic test_reset();
        irq_src = '0; sw_set = '0; mask_we = 1'b0; eoi = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #3;
        checks++; if ({intr, vect, pending, mask, in_service, eoi_lost} !== 21'd0) begin
            errors++; $display("FAIL reset_state: got %h expected 0",
                               {intr, vect, pending, mask, in_service, eoi_lost});
        end
        do_reset();
    endtask

    task automatic test_basic_dispatch();
        do_reset();
        write_mask(8'h06);
        checks++; if (mask !== 8'h06) begin errors++; $display("FAIL mask_readback: got %h expected 06", mask); end
        pulse_src(8'h02);
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL basic_pending: got %h expected 02", pending); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL basic_intr_early: got %b expected 0", intr); end
        tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL basic_intr: got %b expected 1", intr); end
        checks++; if (vect !== VEC_TIMER) begin errors++; $display("FAIL basic_vect: got %0d expected 1", vect); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL basic_pending_clr: got %h expected 00", pending); end
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL basic_in_service: got %b expected 1", in_service); end
        send_eoi();
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL basic_eoi: got %b expected 0", in_service); end
    endtask

    task automatic test_priority();
        logic i0;
        i0 = intr;
        pulse_src(8'h06);
        checks++; if (pending !== 8'h06) begin errors++; $display("FAIL prio_pending: got %h expected 06", pending); end
        tick();
        checks++; if (intr !== ~i0 || vect !== 3'd1) begin
            errors++; $display("FAIL prio_first: got intr=%b vect=%0d expected intr=%b vect=1", intr, vect, ~i0);
        end
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL prio_remaining: got %h expected 04", pending); end
        tick();
        send_eoi();
        checks++; if (intr !== ~i0 || in_service !== 1'b0) begin
            errors++; $display("FAIL prio_gap: got intr=%b in_service=%b expected intr=%b in_service=0", intr, in_service, ~i0);
        end
        tick();
        checks++; if (intr !== i0 || vect !== VEC_KEYB) begin
            errors++; $display("FAIL prio_second: got intr=%b vect=%0d expected intr=%b vect=2", intr, vect, i0);
        end
        send_eoi();
    endtask

    task automatic test_masked_and_level();
        logic i0;
        logic prev;
        int toggles;
        i0 = intr;
        pulse_src(8'h08);
        tick();
        checks++; if (pending !== 8'h00 || intr !== i0) begin
            errors++; $display("FAIL masked_drop: got pending=%h intr=%b expected pending=00 intr=%b", pending, intr, i0);
        end
        irq_src = 8'h04;
        toggles = 0;
        prev = intr;
        for (int k = 0; k < 100; k++) begin
            eoi = (k == 5);
            tick();
            if (intr !== prev) toggles++;
            prev = intr;
        end
        eoi = 1'b0;
        irq_src = '0;
        checks++; if (toggles !== 1) begin errors++; $display("FAIL level_once: got %0d dispatches expected 1", toggles); end
        tick();
    endtask

    task automatic test_watchdog();
        int hits;
        int hit_at;
        logic i0;
        pulse_src(8'h04);
        tick();
        checks++; if (in_service !== 1'b1 || vect !== 3'd2) begin
            errors++; $display("FAIL wdog_dispatch: got in_service=%b vect=%0d expected 1/2", in_service, vect);
        end
        hits = 0; hit_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (eoi_lost === 1'b1) begin hits++; hit_at = k; end
            if (k == 16) begin
                checks++; if (in_service !== 1'b0) begin
                    errors++; $display("FAIL wdog_idle: got in_service=%b expected 0", in_service);
                end
            end
        end
        checks++; if (hits !== 1 || hit_at !== 16) begin
            errors++; $display("FAIL wdog_pulse: got %0d pulses at %0d expected 1 at 16", hits, hit_at);
        end
        i0 = intr;
        send_eoi();
        tick();
        checks++; if (in_service !== 1'b0 || eoi_lost !== 1'b0 || intr !== i0) begin
            errors++; $display("FAIL stray_eoi: got in_service=%b eoi_lost=%b intr=%b expected 0/0/%b",
                               in_service, eoi_lost, intr, i0);
        end
    endtask

    task automatic test_set_beats_clear();
        logic i0;
        do_reset();
        write_mask(8'h06);
        pulse_src(8'h02);
        i0 = intr;
        sw_set = 8'h02;
        tick();
        sw_set = '0;
        checks++; if (intr !== ~i0 || vect !== 3'd1 || pending !== 8'h02) begin
            errors++; $display("FAIL set_beats_clear: got intr=%b vect=%0d pending=%h expected %b/1/02",
                               intr, vect, pending, ~i0);
        end
        send_eoi();
        tick();
        send_eoi();
    endtask

    task automatic test_mask_clears_pending();
        logic i0;
        do_reset();
        write_mask(8'h06);
        pulse_src(8'h02);
        tick();
        pulse_src(8'h04);
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL wait_latch: got %h expected 04", pending); end
        write_mask(8'h02);
        checks++; if (pending !== 8'h00 || mask !== 8'h02) begin
            errors++; $display("FAIL mask_clear: got pending=%h mask=%h expected 00/02", pending, mask);
        end
        i0 = intr;
        send_eoi();
        repeat (3) tick();
        checks++; if (intr !== i0 || in_service !== 1'b0) begin
            errors++; $display("FAIL mask_no_dispatch: got intr=%b in_service=%b expected %b/0", intr, in_service, i0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        write_mask(8'h06);
        pulse_src(8'h02);
        tick();
        pulse_src(8'h04);
        checks++; if (pending !== 8'h04 || in_service !== 1'b1 || intr !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got pending=%h in_service=%b intr=%b expected 04/1/1", pending, in_service, intr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (intr !== 1'b0 || vect !== 3'd0 || pending !== 8'h00 || in_service !== 1'b0) begin
            errors++; $display("FAIL async_reset: got intr=%b vect=%0d pending=%h in_service=%b expected all 0",
                               intr, vect, pending, in_service);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) irq_src = 8'($urandom);
            sw_set  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            mask_we = ($urandom_range(0, 11) == 0);
            mask_d  = 8'($urandom);
            eoi     = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if (pending !== m_pending || mask !== m_mask || intr !== m_intr || vect !== m_vect ||
                in_service !== m_busy || eoi_lost !== m_lost) begin
                errors++;
                $display("FAIL random_cycle_%0d: got p=%h m=%h i=%b v=%0d s=%b l=%b expected p=%h m=%h i=%b v=%0d s=%b l=%b",
                         k, pending, mask, intr, vect, in_service, eoi_lost,
                         m_pending, m_mask, m_intr, m_vect, m_busy, m_lost);
            end
        end
        irq_src = '0; sw_set = '0; mask_we = 1'b0; eoi = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_dispatch();
        test_priority();
        test_masked_and_level();
        test_watchdog();
        test_set_beats_clear();
        test_mask_clears_pending();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
